// File: rtl/alu_issue_decode.sv
// Decode/issue stage between instruction fetch and the ALU: field decode, register-file
// read addressing, scoreboard hazard stalls and a one-entry registered issue bundle.
module alu_issue_decode #(
  parameter int unsigned SB_ENABLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:31] if_instr,
  input  logic        if_valid,
  output logic        if_ready,
  output logic [4:0]  rf_rA_addr,
  output logic [4:0]  rf_rB_addr,
  input  logic [0:63] rf_rA_data,
  input  logic [0:63] rf_rB_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [0:63] rA_64bit_val,
  output logic [0:63] rB_64bit_val,
  output logic [5:0]  Op_code,
  output logic [5:0]  R_ins,
  output logic [1:0]  WW,
  output logic [4:0]  rD_addr,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  output logic        illegal_instr
);

  localparam logic [5:0] OpRAlu  = 6'b101010;
  localparam logic [5:0] OpLoad  = 6'b100000;
  localparam logic [5:0] OpStore = 6'b100001;
  localparam logic [5:0] OpBez   = 6'b100010;
  localparam logic [5:0] OpBnz   = 6'b100011;
  localparam logic [5:0] OpNop   = 6'b111100;
  localparam logic [5:0] FnVnot  = 6'b000100;
  localparam logic [5:0] FnVmov  = 6'b000101;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e      state_q;
  logic [31:0] busy_q, busy_d;
  logic        illegal_q;
  logic [0:63] ra_val_q, rb_val_q;
  logic [5:0]  opc_q, rins_q;
  logic [1:0]  ww_q;
  logic [4:0]  rd_q;

  logic [5:0] opcode, rfn;
  logic [4:0] rd, ra, rb;
  logic [1:0] ww;
  logic       is_ralu, is_load, is_store, is_nop, supported;
  logic       chk_ra, chk_rb, writer, stall, consume, issue;
  logic       unused_bits;

  assign opcode      = if_instr[0:5];
  assign rd          = if_instr[6:10];
  assign ra          = if_instr[11:15];
  assign rb          = if_instr[16:20];
  assign ww          = if_instr[24:25];
  assign rfn         = if_instr[26:31];
  assign unused_bits = ^if_instr[21:23];

  always_comb begin
    is_ralu   = (opcode == OpRAlu);
    is_load   = (opcode == OpLoad);
    is_store  = (opcode == OpStore);
    is_nop    = (opcode == OpNop);
    supported = is_ralu || is_load || is_store || is_nop || (opcode == OpBez) ||
                (opcode == OpBnz);
    rf_rA_addr = ra;
    rf_rB_addr = is_store ? rd : rb;
    chk_ra = supported && !is_nop;
    chk_rb = (is_ralu && (rfn != FnVnot) && (rfn != FnVmov)) || is_store;
    writer = is_ralu || is_load;
    // busy_q[0] is never set, so r0 can never cause a stall.
    stall  = (SB_ENABLE != 0) && ((chk_ra && busy_q[ra]) || (chk_rb && busy_q[rf_rB_addr]) ||
                                  (writer && busy_q[rd]));
    // Unsupported opcodes and NOP are always swallowed without issue.
    if_ready = !reset && (!supported || is_nop || (!stall && (state_q == StEmpty || ex_ready)));
    consume  = if_valid && if_ready;
    issue    = consume && supported && !is_nop;
  end

  // A writeback clear and a same-cycle issue set of one register: the set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (issue && writer && (rd != 5'd0)) busy_d[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      busy_q    <= '0;
      illegal_q <= 1'b0;
      ra_val_q  <= '0;
      rb_val_q  <= '0;
      opc_q     <= '0;
      rins_q    <= '0;
      ww_q      <= '0;
      rd_q      <= '0;
    end else begin
      busy_q    <= busy_d;
      illegal_q <= consume && !supported;
      case (state_q)
        StEmpty: if (issue) state_q <= StFull;
        StFull:  if (ex_ready && !issue) state_q <= StEmpty;
        default: state_q <= StEmpty;
      endcase
      if (issue) begin
        ra_val_q <= rf_rA_data;
        rb_val_q <= rf_rB_data;
        opc_q    <= opcode;
        rins_q   <= rfn;
        ww_q     <= ww;
        rd_q     <= rd;
      end
    end
  end

  assign ex_valid      = (state_q == StFull);
  assign rA_64bit_val  = ra_val_q;
  assign rB_64bit_val  = rb_val_q;
  assign Op_code       = opc_q;
  assign R_ins         = rins_q;
  assign WW            = ww_q;
  assign rD_addr       = rd_q;
  assign illegal_instr = illegal_q;

endmodule

// File: doc/alu_issue_decode.md
ALU_ISSUE_DECODE -- requirements
Module: alu_issue_decode

Interface
REQ-001 Parameter SB_ENABLE, default 1: 1 enables the register scoreboard; 0 disables all hazard stalls.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_instr  input  32 [0:31]  instruction: [0:5] opcode, [6:10] rD, [11:15] rA, [16:20] rB, [24:25] WW, [26:31] R function.
REQ-005 if_valid  input  1  if_instr valid.
REQ-006 if_ready  output  1  decoder accepts if_instr this cycle.
REQ-007 rf_rA_addr, rf_rB_addr  output  5 each  register-file read addresses, combinational from if_instr.
REQ-008 rf_rA_data, rf_rB_data  input  64 [0:63] each  same-cycle read data; the register file is write-through.
REQ-009 ex_valid  output  1  issue bundle valid.
REQ-010 ex_ready  input  1  ALU stage accepts the bundle.
REQ-011 rA_64bit_val, rB_64bit_val  output  64 [0:63] each  registered operands.
REQ-012 Op_code, R_ins  output  6 each; WW  output  2; rD_addr  output  5  registered decoded fields.
REQ-013 wb_valid  input  1; wb_addr  input  5  writeback of rD, clears its scoreboard bit.
REQ-014 illegal_instr  output  1  one-cycle pulse when an unsupported opcode is consumed.

Function
REQ-015 Supported opcodes: R_ALU 101010, LOAD 100000, STORE 100001, BRANCH_EZ 100010, BRANCH_NZ 100011, NOP 111100.
REQ-016 rf_rA_addr = instr[11:15]; rf_rB_addr = instr[6:10] for STORE, otherwise instr[16:20].
REQ-017 Sources checked: rA for all except NOP; rB for R_ALU with R_ins not VNOT 000100 / VMOV 000101, and for STORE.
REQ-018 Writers: R_ALU and LOAD write rD; issuing one sets busy[rD]; rD busy also stalls (WAW).
REQ-019 Stall when SB_ENABLE=1 and any checked source or writer's rD is busy.
REQ-020 Output register FSM, states EMPTY/FULL: EMPTY->FULL on issue; FULL->EMPTY on ex_ready without issue; FULL->FULL on ex_ready with issue.
REQ-021 if_ready = !stall && (state==EMPTY || ex_ready), with supported opcodes only; unsupported opcodes and NOP give if_ready=1 and are consumed without issue.
REQ-022 Issue = if_valid && if_ready && opcode not NOP and supported; bundle is captured at the edge; ex_valid rises the next cycle (1-cycle latency).
REQ-023 While ex_valid=1 and ex_ready=0, every output bit holds stable.
REQ-024 wb_valid clears busy[wb_addr] at the edge; a clear takes effect for the stall check only in the next cycle.
REQ-025 Same-cycle issue setting busy[x] and wb clearing busy[x]: set wins.
REQ-026 Register 0 is never marked busy and never stalls.
REQ-027 WW and R_ins are passed unchanged for every issued opcode; decoding of them is left to the ALU.
REQ-028 illegal_instr pulses in the cycle after an unsupported opcode is consumed.

Reset
REQ-029 On reset: state EMPTY, ex_valid=0, all busy bits 0, illegal_instr=0, all registered data outputs 0.
REQ-030 Reset mid-operation discards any held bundle and scoreboard with no partial issue; if_ready is 0 during the reset cycle.

Verification
REQ-031 Reset, then R_ALU VADD rD=3, rA=1, rB=2, WW=01, ex_ready=1 -> next cycle ex_valid=1, Op_code=101010, R_ins=000110, WW=01, rD_addr=3, operands equal rf data.
REQ-032 Issue VADD rD=3, then VAND rA=3 back-to-back -> if_ready=0 until wb_valid with wb_addr=3; VAND issues one cycle after wb.
REQ-033 ex_ready held 0 for 5 cycles with bundle in FULL -> outputs constant, if_ready=0; ex_ready=1 with a new instr valid -> back-to-back issue, no bubble.
REQ-034 Opcode 000000 presented -> consumed, illegal_instr=1 for one cycle, ex_valid stays 0; NOP 111100 -> consumed, no pulse, no issue.
REQ-035 Same-cycle wb_addr=5 and issue of a writer with rD=5 -> busy[5]=1 afterwards; a reader of r5 stalls.
REQ-036 SB_ENABLE=0, dependent pair rD=4 then rA=4 -> both issue on consecutive cycles; reset asserted while FULL -> ex_valid=0 the next cycle.
